// File: rtl/vec_ctrl_pkg.sv
// Shared types and constants for the vector processor command path.
package vec_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_STORE = 2'b01,
    OP_MUL   = 2'b10,
    OP_SUM   = 2'b11
  } opcode_e;

  typedef struct packed {
    opcode_e     opcode;
    logic [9:0]  entry1;
    logic [1:0]  entry2;
  } vec_cmd_t;

  localparam int MEM_DEPTH_DEF = 512;
  localparam int VEC_ROWS      = 16;

  function automatic logic is_alu(opcode_e op);
    return (op == OP_MUL) || (op == OP_SUM);
  endfunction

  // Only loads into r0/r1 feed the ALU operands, so only those create a hazard.
  function automatic logic is_hazard_load(vec_cmd_t cmd);
    return (cmd.opcode == OP_LOAD) && (cmd.entry2 < 2'd2);
  endfunction

endpackage

// File: rtl/vec_cmd_arbiter_if.sv
// Requester-side handshake and processor-side command bus of the arbiter.
interface vec_cmd_arbiter_if;
  import vec_ctrl_pkg::*;

  logic [1:0]           req_valid;
  vec_cmd_t [1:0]       req_cmd;
  logic [1:0]           req_ready;
  logic                 proc_en;
  logic [1:0]           proc_opcode;
  logic [9:0]           proc_entry1;
  logic [1:0]           proc_entry2;
  logic                 err_valid;
  logic                 err_id;
  logic [15:0]          issue_count;

  modport master (
    output req_valid, req_cmd,
    input  req_ready, proc_en, proc_opcode, proc_entry1, proc_entry2,
           err_valid, err_id, issue_count
  );

  modport slave (
    input  req_valid, req_cmd,
    output req_ready, proc_en, proc_opcode, proc_entry1, proc_entry2,
           err_valid, err_id, issue_count
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer only moves when the caller
// reports that the granted command was actually consumed.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] eligible,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;  // 1: requester 1 wins the next tie

  always_comb begin
    grant = 2'b00;
    if (eligible == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end else begin
      grant = eligible;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/vec_cmd_arbiter.sv
// Arbitrates two command requesters onto the vector processor, rejecting
// out-of-range indices and holding off ALU ops after loads into r0/r1.
module vec_cmd_arbiter
  import vec_ctrl_pkg::*;
#(
  parameter int LOAD_USE_GAP = 1,
  parameter int MEM_DEPTH    = MEM_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  vec_cmd_arbiter_if.slave   bus
);

  localparam int HZW = (LOAD_USE_GAP > 1) ? $clog2(LOAD_USE_GAP + 1) : 1;

  logic [HZW-1:0] hz_cnt;
  logic           hz_busy;
  logic [1:0]     eligible;
  logic [1:0]     grant;
  logic [1:0]     ready;
  logic           accept;
  logic           gid;
  vec_cmd_t       cmd;
  logic [31:0]    entry1_w;
  logic           range_err;
  logic           issue_ok;

  logic           proc_en_q;
  logic [1:0]     proc_opcode_q;
  logic [9:0]     proc_entry1_q;
  logic [1:0]     proc_entry2_q;
  logic           err_valid_q;
  logic           err_id_q;
  logic [15:0]    issue_count_q;

  assign hz_busy = (hz_cnt != '0);

  always_comb begin
    eligible = 2'b00;
    for (int i = 0; i < 2; i++) begin
      eligible[i] = bus.req_valid[i] && !(hz_busy && is_alu(bus.req_cmd[i].opcode));
    end
  end

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (eligible),
    .advance  (issue_ok),
    .grant    (grant)
  );

  // No acceptance while held in reset, even though the arbiter state is valid.
  assign ready     = grant & {2{rst_n}};
  assign accept    = |ready;
  assign gid       = grant[1];
  assign cmd       = bus.req_cmd[gid];
  assign entry1_w  = 32'(cmd.entry1);
  assign range_err = (entry1_w >= 32'(MEM_DEPTH));
  assign issue_ok  = accept && !range_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proc_en_q     <= 1'b0;
      proc_opcode_q <= 2'b00;
      proc_entry1_q <= '0;
      proc_entry2_q <= 2'b00;
      err_valid_q   <= 1'b0;
      err_id_q      <= 1'b0;
      issue_count_q <= '0;
      hz_cnt        <= '0;
    end else begin
      proc_en_q   <= issue_ok;
      err_valid_q <= accept && range_err;
      if (issue_ok) begin
        proc_opcode_q <= cmd.opcode;
        proc_entry1_q <= cmd.entry1;
        proc_entry2_q <= cmd.entry2;
        issue_count_q <= issue_count_q + 16'd1;
      end
      if (accept && range_err) begin
        err_id_q <= gid;
      end
      if ((LOAD_USE_GAP != 0) && issue_ok && is_hazard_load(cmd)) begin
        hz_cnt <= HZW'(LOAD_USE_GAP);
      end else if (hz_busy) begin
        hz_cnt <= hz_cnt - 1'b1;
      end
    end
  end

  assign bus.req_ready   = ready;
  assign bus.proc_en     = proc_en_q;
  assign bus.proc_opcode = proc_opcode_q;
  assign bus.proc_entry1 = proc_entry1_q;
  assign bus.proc_entry2 = proc_entry2_q;
  assign bus.err_valid   = err_valid_q;
  assign bus.err_id      = err_id_q;
  assign bus.issue_count = issue_count_q;

endmodule

// File: tb/tb_vec_cmd_arbiter.sv
// Bench for vec_cmd_arbiter: hand-computed vector table through a scoreboard
// queue, plus a mid-stream reset sequence.
module tb_vec_cmd_arbiter;
  import vec_ctrl_pkg::*;

  localparam int LD = 0, ST = 1, MUL = 2, SUM = 3;
  localparam int NV = 18;

  typedef struct {
    logic        en;
    logic [1:0]  op;
    logic [9:0]  e1;
    logic [1:0]  e2;
    logic        err;
    logic        eid;
    logic [15:0] cnt;
  } exp_t;

  typedef struct {
    logic [1:0]  valid;
    logic [13:0] c0;
    logic [13:0] c1;
    logic [1:0]  rdy;
    exp_t        out;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  vec_t vecs[NV];

  always #5 clk = ~clk;

  vec_cmd_arbiter_if bus();

  vec_cmd_arbiter #(.LOAD_USE_GAP(1), .MEM_DEPTH(512)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [13:0] mk(int op, int e1, int e2);
    return {op[1:0], e1[9:0], e2[1:0]};
  endfunction

  function automatic exp_t ex(logic en, int op, int e1, int e2, logic err, logic eid, int cnt);
    exp_t e;
    e.en = en; e.op = op[1:0]; e.e1 = e1[9:0]; e.e2 = e2[1:0];
    e.err = err; e.eid = eid; e.cnt = cnt[15:0];
    return e;
  endfunction

  function automatic vec_t mv(logic [1:0] v, logic [13:0] c0, logic [13:0] c1,
                              logic [1:0] rdy, exp_t o);
    vec_t r;
    r.valid = v; r.c0 = c0; r.c1 = c1; r.rdy = rdy; r.out = o;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic check_out(string tag, exp_t e);
    chk({tag, ".proc_en"},     32'(bus.proc_en),     32'(e.en));
    chk({tag, ".proc_opcode"}, 32'(bus.proc_opcode), 32'(e.op));
    chk({tag, ".proc_entry1"}, 32'(bus.proc_entry1), 32'(e.e1));
    chk({tag, ".proc_entry2"}, 32'(bus.proc_entry2), 32'(e.e2));
    chk({tag, ".err_valid"},   32'(bus.err_valid),   32'(e.err));
    if (e.err) chk({tag, ".err_id"}, 32'(bus.err_id), 32'(e.eid));
    chk({tag, ".issue_count"}, 32'(bus.issue_count), 32'(e.cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t got_e;

    // Round-robin burst of stores, then hazard, bypass, range errors, pointer hold.
    vecs[0]  = mv(2'b11, mk(ST,10,2),  mk(ST,20,3), 2'b01, ex(1,ST,10,2,0,0,1));
    vecs[1]  = mv(2'b11, mk(ST,10,2),  mk(ST,20,3), 2'b10, ex(1,ST,20,3,0,0,2));
    vecs[2]  = mv(2'b11, mk(ST,10,2),  mk(ST,20,3), 2'b01, ex(1,ST,10,2,0,0,3));
    vecs[3]  = mv(2'b11, mk(ST,10,2),  mk(ST,20,3), 2'b10, ex(1,ST,20,3,0,0,4));
    vecs[4]  = mv(2'b00, mk(ST,0,0),   mk(ST,0,0),  2'b00, ex(0,ST,20,3,0,0,4));
    vecs[5]  = mv(2'b01, mk(LD,5,0),   mk(ST,0,0),  2'b01, ex(1,LD,5,0,0,0,5));
    vecs[6]  = mv(2'b10, mk(LD,0,0),   mk(MUL,7,1), 2'b00, ex(0,LD,5,0,0,0,5));
    vecs[7]  = mv(2'b10, mk(LD,0,0),   mk(MUL,7,1), 2'b10, ex(1,MUL,7,1,0,0,6));
    vecs[8]  = mv(2'b01, mk(LD,8,3),   mk(ST,0,0),  2'b01, ex(1,LD,8,3,0,0,7));
    vecs[9]  = mv(2'b10, mk(LD,0,0),   mk(MUL,9,0), 2'b10, ex(1,MUL,9,0,0,0,8));
    vecs[10] = mv(2'b01, mk(ST,512,0), mk(ST,0,0),  2'b01, ex(0,MUL,9,0,1,0,8));
    vecs[11] = mv(2'b11, mk(ST,1,0),   mk(ST,2,1),  2'b01, ex(1,ST,1,0,0,0,9));
    vecs[12] = mv(2'b10, mk(ST,1,0),   mk(ST,600,2),2'b10, ex(0,ST,1,0,1,1,9));
    vecs[13] = mv(2'b11, mk(ST,3,0),   mk(ST,4,1),  2'b10, ex(1,ST,4,1,0,0,10));
    vecs[14] = mv(2'b01, mk(LD,511,1), mk(ST,0,0),  2'b01, ex(1,LD,511,1,0,0,11));
    vecs[15] = mv(2'b11, mk(SUM,0,2),  mk(LD,500,2),2'b10, ex(1,LD,500,2,0,0,12));
    vecs[16] = mv(2'b11, mk(SUM,0,2),  mk(ST,6,0),  2'b01, ex(1,SUM,0,2,0,0,13));
    vecs[17] = mv(2'b00, mk(ST,0,0),   mk(ST,0,0),  2'b00, ex(0,SUM,0,2,0,0,13));

    rst_n = 1'b0;
    bus.req_valid  = 2'b11;
    bus.req_cmd[0] = mk(ST,1,0);
    bus.req_cmd[1] = mk(ST,2,0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
    check_out("rst", ex(0,0,0,0,0,0,0));
    chk("rst.err_id", 32'(bus.err_id), 32'd0);

    @(negedge clk);
    bus.req_valid = 2'b00;
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.req_valid  = vecs[i].valid;
      bus.req_cmd[0] = vecs[i].c0;
      bus.req_cmd[1] = vecs[i].c1;
      #1;
      chk($sformatf("v%0d.req_ready", i), 32'(bus.req_ready), 32'(vecs[i].rdy));
      exp_q.push_back(vecs[i].out);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL v%0d.scoreboard: got empty queue, expected one entry", i);
      end else begin
        got_e = exp_q.pop_front();
        check_out($sformatf("v%0d", i), got_e);
      end
    end

    // Reset in the middle of a burst; the first tie afterwards goes to requester 0.
    @(negedge clk);
    bus.req_valid  = 2'b11;
    bus.req_cmd[0] = mk(ST,30,0);
    bus.req_cmd[1] = mk(ST,31,1);
    #1;
    chk("mr.pre_ready", 32'(bus.req_ready), 32'b10);
    @(posedge clk);
    #1;
    check_out("mr.pre", ex(1,ST,31,1,0,0,14));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr.in_rst_ready", 32'(bus.req_ready), 32'd0);
    check_out("mr.in_rst", ex(0,0,0,0,0,0,0));
    @(posedge clk);
    #1;
    check_out("mr.held", ex(0,0,0,0,0,0,0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mr.post_ready", 32'(bus.req_ready), 32'b01);
    @(posedge clk);
    #1;
    check_out("mr.post", ex(1,ST,30,0,0,0,1));

    @(negedge clk);
    bus.req_valid = 2'b00;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
